// File: rtl/alu_result_pipe_if.sv
// Purpose : operand/result handshake bundle for the registered ALU stage.
// Latency : n/a (wires only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// Ports   : master drives operands and out_ready; slave (the ALU stage)
//           drives in_ready, result, flags and the debug op counter.
interface alu_result_pipe_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, A, B, op, out_ready,
      input  in_ready, out_valid, result, zero, negative, carry, overflow, op_count
   );

   modport slave (
      input  in_valid, A, B, op, out_ready,
      output in_ready, out_valid, result, zero, negative, carry, overflow, op_count
   );
endinterface

// File: rtl/alu_result_pipe.sv
// Purpose : two-register ALU stage (operand reg -> compute -> result/flag reg).
// Latency : 2 edges from the accepting edge path: operands captured, then result captured.
// Backpressure: holds at most 2 ops; in_ready drops only when both stages are full and out_ready=0.
// Ports   : clk, rst_n (async active-low); bus = slave side of alu_result_pipe_if
//           (in_valid/in_ready/A/B/op in, out_valid/out_ready/result/flags/op_count out).
module alu_result_pipe #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              rst_n,
   alu_result_pipe_if.slave bus
);

   localparam int MSB = WIDTH - 1;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   // stage 1: registered operands
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_op;

   // stage 2: registered result and flags, drive the outputs directly
   logic             s2_valid;
   logic [WIDTH-1:0] s2_result;
   logic             s2_zero;
   logic             s2_negative;
   logic             s2_carry;
   logic             s2_overflow;
   logic [CNT_W-1:0] op_count;

   logic s2_ready;
   logic s1_ready;

   // combinational ALU on stage-1 contents
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH-1:0] nxt_result;
   logic             nxt_carry;
   logic             nxt_overflow;

   assign s2_ready = !s2_valid || bus.out_ready;
   assign s1_ready = !s1_valid || s2_ready;

   // extra top bit holds carry-out for ADD and borrow for SUB
   assign sum_ext  = {1'b0, s1_a} + {1'b0, s1_b};
   assign diff_ext = {1'b0, s1_a} - {1'b0, s1_b};

   always_comb begin
      nxt_result   = '0;
      nxt_carry    = 1'b0;
      nxt_overflow = 1'b0;
      case (s1_op)
         OP_AND: nxt_result = s1_a & s1_b;
         OP_OR:  nxt_result = s1_a | s1_b;
         OP_XOR: nxt_result = s1_a ^ s1_b;
         OP_NOT: nxt_result = ~s1_a;
         OP_ADD: begin
            nxt_result   = sum_ext[MSB:0];
            nxt_carry    = sum_ext[WIDTH];
            // like-signed operands giving a different-signed sum
            nxt_overflow = (s1_a[MSB] == s1_b[MSB]) && (sum_ext[MSB] != s1_a[MSB]);
         end
         OP_SUB: begin
            nxt_result   = diff_ext[MSB:0];
            nxt_carry    = diff_ext[WIDTH];
            // unlike-signed operands where the difference loses A's sign
            nxt_overflow = (s1_a[MSB] != s1_b[MSB]) && (diff_ext[MSB] != s1_a[MSB]);
         end
         OP_SHL: begin
            nxt_result = {s1_a[MSB-1:0], 1'b0};
            nxt_carry  = s1_a[MSB];
         end
         OP_SHR: begin
            nxt_result = {1'b0, s1_a[MSB:1]};
            nxt_carry  = s1_a[0];
         end
         default: nxt_result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
      end else begin
         if (s1_ready) begin
            s1_valid <= bus.in_valid;
         end
         if (bus.in_valid && s1_ready) begin
            s1_a  <= bus.A;
            s1_b  <= bus.B;
            s1_op <= bus.op;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid    <= 1'b0;
         s2_result   <= '0;
         s2_zero     <= 1'b0;
         s2_negative <= 1'b0;
         s2_carry    <= 1'b0;
         s2_overflow <= 1'b0;
      end else begin
         if (s2_ready) begin
            s2_valid <= s1_valid;
         end
         // result regs keep their value when stage 2 drains, so the bus stays quiet
         if (s1_valid && s2_ready) begin
            s2_result   <= nxt_result;
            s2_zero     <= (nxt_result == '0);
            s2_negative <= nxt_result[MSB];
            s2_carry    <= nxt_carry;
            s2_overflow <= nxt_overflow;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (s2_valid && bus.out_ready) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

   assign bus.in_ready  = s1_ready;
   assign bus.out_valid = s2_valid;
   assign bus.result    = s2_result;
   assign bus.zero      = s2_zero;
   assign bus.negative  = s2_negative;
   assign bus.carry     = s2_carry;
   assign bus.overflow  = s2_overflow;
   assign bus.op_count  = op_count;

endmodule

// File: tb/tb_alu_result_pipe.sv
// Purpose : directed and streamed checks of alu_result_pipe against a queue model.
// Latency : result expected after the second edge following acceptance.
// Backpressure: exercised with out_ready held low until both stages fill.
module tb_alu_result_pipe;

   localparam int W  = 4;
   localparam int CW = 4;
   localparam int M  = (1 << W) - 1;
   localparam int H  = 1 << (W - 1);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   alu_result_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   alu_result_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int res;
      int flg;   // {zero, negative, carry, overflow}
      int acc;   // edge number at which the op was accepted
   } exp_t;

   exp_t q[$];
   int   cnt   = 0;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: signed/unsigned arithmetic on plain integers.
   function automatic exp_t model(input int a, input int b, input int o);
      exp_t e;
      int   r, c, v, sa, sb, s;
      c  = 0;
      v  = 0;
      r  = 0;
      sa = (a >= H) ? a - (1 << W) : a;
      sb = (b >= H) ? b - (1 << W) : b;
      case (o)
         0: r = a & b;
         1: r = a | b;
         2: r = a ^ b;
         3: r = M - a;
         4: begin
            s = a + b;
            r = s % (1 << W);
            c = (s > M) ? 1 : 0;
            v = (sa + sb > H - 1 || sa + sb < -H) ? 1 : 0;
         end
         5: begin
            r = (a - b + (1 << W)) % (1 << W);
            c = (a < b) ? 1 : 0;
            v = (sa - sb > H - 1 || sa - sb < -H) ? 1 : 0;
         end
         6: begin
            r = (a * 2) % (1 << W);
            c = (a >= H) ? 1 : 0;
         end
         default: begin
            r = a / 2;
            c = a % 2;
         end
      endcase
      e.res = r;
      e.flg = ((r == 0) ? 8 : 0) + ((r >= H) ? 4 : 0) + c * 2 + v;
      e.acc = 0;
      return e;
   endfunction

   // Model update: occupancy-based transfers, evaluated on pre-edge values.
   exp_t m_e;
   bit   m_ov, m_ir;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         cnt = 0;
      end else begin
         m_ov = (q.size() > 0) && (q[0].acc + 2 <= cyc);
         m_ir = (q.size() < 2) || bus.out_ready;
         if (m_ov && bus.out_ready) begin
            void'(q.pop_front());
            cnt = (cnt + 1) % (1 << CW);
         end
         if (bus.in_valid && m_ir) begin
            m_e     = model(int'(bus.A), int'(bus.B), int'(bus.op));
            m_e.acc = cyc;
            q.push_back(m_e);
         end
         cyc++;
      end
   end

   // Every-cycle compare on the falling edge.
   bit c_ov, c_ir;
   always @(negedge clk) begin
      c_ov = (q.size() > 0) && (q[0].acc + 2 <= cyc);
      c_ir = (q.size() < 2) || bus.out_ready;
      chk("in_ready", bus.in_ready, c_ir);
      chk("out_valid", bus.out_valid, c_ov);
      chk("op_count", bus.op_count, cnt);
      if (c_ov) begin
         chk("result", bus.result, q[0].res);
         chk("flags", {bus.zero, bus.negative, bus.carry, bus.overflow}, q[0].flg);
      end else if (!rst_n) begin
         chk("rst_result", bus.result, 0);
         chk("rst_flags", {bus.zero, bus.negative, bus.carry, bus.overflow}, 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input int a, input int b, input int o);
      int t;
      bit acc;
      bus.in_valid = 1'b1;
      bus.A        = W'(a);
      bus.B        = W'(b);
      bus.op       = 3'(o);
      t            = 0;
      do begin
         acc = bus.in_ready;
         step();
         t++;
      end while (!acc && t < 50);
      if (!acc) chk("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   // directed vectors: {A, B, op}
   int dv[8][3] = '{
      '{10, 11, 0}, '{0, 15, 0}, '{15, 1, 4}, '{7, 1, 4},
      '{3, 5, 5},   '{8, 1, 5},  '{9, 0, 6},  '{3, 0, 7}
   };
   // hand-computed {result, flags} for dv
   int dx[8][2] = '{
      '{10, 4}, '{0, 8}, '{0, 10}, '{8, 5},
      '{14, 6}, '{7, 1}, '{2, 2},  '{1, 2}
   };

   initial begin
      exp_t e;
      int   base, c0;
      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.op        = '0;
      bus.out_ready = 1'b1;

      for (int i = 0; i < 8; i++) begin
         e = model(dv[i][0], dv[i][1], dv[i][2]);
         chk($sformatf("model_res_%0d", i), e.res, dx[i][0]);
         chk($sformatf("model_flg_%0d", i), e.flg, dx[i][1]);
      end

      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      step();

      // directed ops, spaced out
      for (int i = 0; i < 8; i++) begin
         send(dv[i][0], dv[i][1], dv[i][2]);
         step();
      end
      repeat (4) step();

      // backpressure: two ops fill the pipe, third waits
      base          = cnt;
      bus.out_ready = 1'b0;
      send(12, 10, 0);
      send(12, 10, 1);
      bus.in_valid  = 1'b1;
      bus.A         = 4'd12;
      bus.B         = 4'd10;
      bus.op        = 3'd2;
      repeat (3) step();
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_hold_result", bus.result, 8);
      bus.out_ready = 1'b1;
      step();
      bus.in_valid  = 1'b0;
      repeat (4) step();
      chk("bp_count", bus.op_count, (base + 3) % (1 << CW));

      // streaming: one op per edge with no backpressure
      c0 = cyc;
      for (int i = 0; i < 20; i++) begin
         send(int'($urandom_range(0, M)), int'($urandom_range(0, M)), int'($urandom_range(0, 7)));
      end
      chk("stream_rate", cyc - c0, 20);
      repeat (4) step();

      // asynchronous reset with two ops in flight
      send(5, 3, 4);
      send(6, 1, 5);
      chk("pre_rst_out_valid", bus.out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_out_valid", bus.out_valid, 0);
      chk("rst_async_result", bus.result, 0);
      chk("rst_async_op_count", bus.op_count, 0);
      chk("rst_async_in_ready", bus.in_ready, 1);
      step();
      rst_n = 1'b1;
      repeat (3) step();
      send(9, 9, 2);
      chk("post_rst_latency_lo", bus.out_valid, 0);
      step();
      chk("post_rst_latency_hi", bus.out_valid, 1);
      chk("post_rst_zero", bus.zero, 1);
      repeat (3) step();
      chk("post_rst_count", bus.op_count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end

endmodule
